// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multi-cycle RISC-V datapath: steps fetch/decode/execute/
// memory/writeback, drives datapath selects and enables, traps on illegal ops or memory timeout.
module multicycle_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 3,
  parameter int MEM_TIMEOUT   = 15,
  parameter int TIMEOUT_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    instr,
  input  logic                     Zero,
  input  logic                     mem_ready,
  output logic                     PCWrite,
  output logic                     AdrSrc,
  output logic                     MemWrite,
  output logic                     IRWrite,
  output logic [1:0]               ResultSrc,
  output logic [1:0]               ALUSrcA,
  output logic [1:0]               ALUSrcB,
  output logic [CONTROL_WIDTH-1:0] ALUControl,
  output logic [1:0]               ImmSrc,
  output logic                     RegWrite,
  output logic                     instr_retired,
  output logic                     trap,
  output logic [1:0]               trap_cause
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [CONTROL_WIDTH-1:0] ALU_ADD = CONTROL_WIDTH'(3'b000);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SUB = CONTROL_WIDTH'(3'b001);
  localparam logic [CONTROL_WIDTH-1:0] ALU_AND = CONTROL_WIDTH'(3'b010);
  localparam logic [CONTROL_WIDTH-1:0] ALU_OR  = CONTROL_WIDTH'(3'b011);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SLT = CONTROL_WIDTH'(3'b101);

  // The trap cause lives in the state encoding, so no separate cause register is needed.
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH, S_TRAP_ILL, S_TRAP_TMO
  } state_t;

  state_t                   state, state_n;
  logic [TIMEOUT_WIDTH-1:0] wait_cnt;
  logic [6:0]               op;
  logic [2:0]               funct3;
  logic                     funct7b5;
  logic                     mem_wait, mem_timeout;
  logic                     instr_unused;

  assign op           = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7b5     = instr[30];
  assign instr_unused = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

  function automatic logic alu_legal(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic [CONTROL_WIDTH-1:0] alu_decode(input logic [2:0] f3,
                                                          input logic is_sub);
    case (f3)
      3'b000:  return is_sub ? ALU_SUB : ALU_ADD;
      3'b010:  return ALU_SLT;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  assign mem_wait    = (state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE) && !mem_ready;
  assign mem_timeout = (MEM_TIMEOUT != 0) && mem_wait &&
                       (wait_cnt == TIMEOUT_WIDTH'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= mem_wait ? wait_cnt + TIMEOUT_WIDTH'(1) : '0;
    end
  end

  always_comb begin
    state_n       = state;
    PCWrite       = 1'b0;
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUControl    = ALU_ADD;
    RegWrite      = 1'b0;
    instr_retired = 1'b0;
    trap          = 1'b0;
    trap_cause    = 2'b00;

    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase

    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready)        state_n = S_DECODE;
        else if (mem_timeout) state_n = S_TRAP_TMO;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_R:         state_n = alu_legal(funct3) ? S_EXECR : S_TRAP_ILL;
          OP_I:         state_n = alu_legal(funct3) ? S_EXECI : S_TRAP_ILL;
          OP_BR:        state_n = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP_ILL;
          OP_JAL:       state_n = S_JAL;
          default:      state_n = S_TRAP_ILL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_n = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready)        state_n = S_MEMWB;
        else if (mem_timeout) state_n = S_TRAP_TMO;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
        state_n       = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        MemWrite      = 1'b1;
        instr_retired = mem_ready;
        if (mem_ready)        state_n = S_FETCH;
        else if (mem_timeout) state_n = S_TRAP_TMO;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_decode(funct3, funct7b5);
        state_n    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(funct3, 1'b0);
        state_n    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
        state_n       = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_n = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA       = 2'b10;
        ALUControl    = ALU_SUB;
        PCWrite       = Zero ^ funct3[0];
        instr_retired = 1'b1;
        state_n       = S_FETCH;
      end
      S_TRAP_ILL: begin
        trap       = 1'b1;
        trap_cause = 2'b01;
      end
      S_TRAP_TMO: begin
        trap       = 1'b1;
        trap_cause = 2'b10;
      end
      default: state_n = S_FETCH;
    endcase

    // Strobes must stay quiet for the whole reset cycle, whatever state is being left.
    if (rst) begin
      PCWrite       = 1'b0;
      IRWrite       = 1'b0;
      MemWrite      = 1'b0;
      RegWrite      = 1'b0;
      instr_retired = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus randomized instructions checked
// against a latency/strobe-count model derived from the instruction class.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst, Zero, mem_ready;
  logic [31:0] instr;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_retired, trap;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, trap_cause;
  logic [2:0]  ALUControl;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .instr_retired(instr_retired),
    .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [1:0] s_rsrc[64], s_srca[64], s_srcb[64], s_imm[64];
  logic [2:0] s_alu[64];
  logic       s_adr[64], s_mw[64], s_rw[64], s_pcw[64], s_irw[64], s_ret[64];
  int         n_cyc;
  logic       got_trap;
  logic [1:0] got_cause;

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] LW   = 32'h0000A103;
  localparam logic [31:0] SW   = 32'h0020A023;

  function automatic logic [31:0] r_type(input logic f7b5, input logic [2:0] f3);
    return {1'b0, f7b5, 5'b0, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b0110011};
  endfunction
  function automatic logic [31:0] i_type(input logic [6:0] op, input logic [2:0] f3, input logic b30);
    return {1'b0, b30, 10'($urandom), 5'($urandom), f3, 5'($urandom), op};
  endfunction

  // Drives one instruction from FETCH: mem_ready low for fw fetch cycles and for mw cycles
  // of the memory access phase; records every cycle's outputs until retire, trap or maxc.
  task automatic run_instr(input logic [31:0] ins, input logic z, input int fw, input int mw,
                           input int maxc);
    int c;
    bit done;
    c = 0; done = 0; got_trap = 0; got_cause = 2'b00;
    while (!done && c < maxc) begin
      instr = ins; Zero = z;
      mem_ready = !((c < fw) || (c >= fw + 3 && c < fw + 3 + mw));
      @(negedge clk);
      if (c < 64) begin
        s_rsrc[c] = ResultSrc; s_srca[c] = ALUSrcA; s_srcb[c] = ALUSrcB; s_imm[c] = ImmSrc;
        s_alu[c] = ALUControl; s_adr[c] = AdrSrc; s_mw[c] = MemWrite; s_rw[c] = RegWrite;
        s_pcw[c] = PCWrite; s_irw[c] = IRWrite; s_ret[c] = instr_retired;
      end
      if (instr_retired) done = 1;
      if (trap) begin done = 1; got_trap = 1; got_cause = trap_cause; end
      c++;
      @(posedge clk); #1;
    end
    n_cyc = c;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b1; Zero = 1'b0; instr = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr = ADDI; mem_ready = 1'b1; Zero = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({PCWrite, IRWrite, MemWrite, RegWrite, instr_retired} !== 5'b0) begin
      failures++; $display("FAIL rst_strobes got=%b exp=00000", {PCWrite, IRWrite, MemWrite, RegWrite, instr_retired}); end
    checks++; if ({trap, trap_cause} !== 3'b000) begin
      failures++; $display("FAIL rst_trap got=%b exp=000", {trap, trap_cause}); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if ({IRWrite, PCWrite, AdrSrc, ALUSrcB, ResultSrc} !== 7'b110_10_10) begin
      failures++; $display("FAIL rst_fetch got=%b exp=1101010", {IRWrite, PCWrite, AdrSrc, ALUSrcB, ResultSrc}); end
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    do_reset();
    run_instr(ADDI, 1'b0, 0, 0, 20);
    checks++; if (n_cyc !== 4) begin failures++; $display("FAIL addi_latency got=%0d exp=4", n_cyc); end
    checks++; if ({s_srcb[0], s_alu[0], s_rsrc[0], s_irw[0], s_pcw[0], s_adr[0]} !== 10'b10_000_10_1_1_0) begin
      failures++; $display("FAIL addi_fetch got=%b exp=1000010110", {s_srcb[0], s_alu[0], s_rsrc[0], s_irw[0], s_pcw[0], s_adr[0]}); end
    checks++; if ({s_srca[1], s_srcb[1], s_alu[1]} !== 7'b01_01_000) begin
      failures++; $display("FAIL addi_decode got=%b exp=0101000", {s_srca[1], s_srcb[1], s_alu[1]}); end
    checks++; if ({s_srca[2], s_srcb[2], s_alu[2]} !== 7'b10_01_000) begin
      failures++; $display("FAIL addi_exec got=%b exp=1001000", {s_srca[2], s_srcb[2], s_alu[2]}); end
    checks++; if ({s_rw[3], s_ret[3], s_rsrc[3]} !== 4'b11_00) begin
      failures++; $display("FAIL addi_wb got=%b exp=1100", {s_rw[3], s_ret[3], s_rsrc[3]}); end
  endtask

  task automatic test_alu_decode();
    logic [31:0] tins[7] = '{32'h40208033, 32'h0020F033, 32'h0020A033, 32'h0020E033,
                             32'h0050E093, 32'h40008093, 32'h0050A093};
    logic [2:0]  talu[7] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b011, 3'b000, 3'b101};
    logic [1:0]  tsrc[7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 7; i++) begin
      run_instr(tins[i], 1'b0, 0, 0, 20);
      checks++; if ({s_srcb[2], s_alu[2]} !== {tsrc[i], talu[i]}) begin
        failures++; $display("FAIL alu_decode[%0d] got=%b exp=%b", i, {s_srcb[2], s_alu[2]}, {tsrc[i], talu[i]}); end
      checks++; if (n_cyc !== 4) begin failures++; $display("FAIL alu_latency[%0d] got=%0d exp=4", i, n_cyc); end
    end
  endtask

  task automatic test_lw_wait();
    int adr;
    run_instr(LW, 1'b0, 0, 3, 30);
    adr = 0;
    for (int k = 0; k < n_cyc; k++) adr += int'(s_adr[k]);
    checks++; if (n_cyc !== 8) begin failures++; $display("FAIL lw_latency got=%0d exp=8", n_cyc); end
    checks++; if (adr !== 4) begin failures++; $display("FAIL lw_adrsrc_cycles got=%0d exp=4", adr); end
    checks++; if ({s_rsrc[7], s_rw[7], s_ret[7], s_imm[0]} !== 6'b01_1_1_00) begin
      failures++; $display("FAIL lw_wb got=%b exp=011100", {s_rsrc[7], s_rw[7], s_ret[7], s_imm[0]}); end
  endtask

  task automatic test_sw_wait();
    int mwc;
    run_instr(SW, 1'b0, 0, 2, 30);
    mwc = 0;
    for (int k = 0; k < n_cyc; k++) mwc += int'(s_mw[k]);
    checks++; if (mwc !== 3) begin failures++; $display("FAIL sw_memwrite_cycles got=%0d exp=3", mwc); end
    checks++; if ({n_cyc[7:0], s_ret[4], s_ret[5], s_imm[2]} !== {8'd6, 1'b0, 1'b1, 2'b01}) begin
      failures++; $display("FAIL sw_retire got=%0d/%b%b/%b exp=6/01/01", n_cyc, s_ret[4], s_ret[5], s_imm[2]); end
  endtask

  task automatic test_branch();
    run_instr(32'h00000063, 1'b1, 0, 0, 20);
    checks++; if ({n_cyc[7:0], s_pcw[2], s_srca[2], s_srcb[2], s_alu[2], s_imm[2]} !== {8'd3, 1'b1, 2'b10, 2'b00, 3'b001, 2'b10}) begin
      failures++; $display("FAIL beq_taken got=%0d/%b exp=3/1", n_cyc, s_pcw[2]); end
    run_instr(32'h00001063, 1'b1, 0, 0, 20);
    checks++; if ({n_cyc[7:0], s_pcw[2], s_ret[2]} !== {8'd3, 1'b0, 1'b1}) begin
      failures++; $display("FAIL bne_not_taken got=%0d/%b exp=3/0", n_cyc, s_pcw[2]); end
  endtask

  task automatic test_jal();
    run_instr(32'h0000006F, 1'b0, 0, 0, 20);
    checks++; if ({n_cyc[7:0], s_pcw[2], s_srca[2], s_srcb[2], s_rw[3], s_imm[0]} !== {8'd4, 1'b1, 2'b01, 2'b10, 1'b1, 2'b11}) begin
      failures++; $display("FAIL jal got=%0d/%b%b%b%b%b exp=4/1011011", n_cyc, s_pcw[2], s_srca[2], s_srcb[2], s_rw[3], s_imm[0]); end
  endtask

  task automatic test_illegal();
    logic [31:0] bad[3] = '{32'h0000007F, 32'h00209033, 32'h00002063};
    for (int i = 0; i < 3; i++) begin
      do_reset();
      run_instr(bad[i], 1'b0, 0, 0, 10);
      checks++; if ({got_trap, got_cause, n_cyc[7:0]} !== {3'b101, 8'd3}) begin
        failures++; $display("FAIL illegal_trap[%0d] got=%b/%0d exp=101/3", i, {got_trap, got_cause}, n_cyc); end
    end
    for (int k = 0; k < 10; k++) begin
      mem_ready = 1'($urandom); Zero = 1'($urandom);
      @(negedge clk);
      checks++; if ({PCWrite, IRWrite, MemWrite, RegWrite, instr_retired, trap, trap_cause} !== 8'b00000_1_01) begin
        failures++; $display("FAIL trap_hold[%0d] got=%b exp=00000101", k, {PCWrite, IRWrite, MemWrite, RegWrite, instr_retired, trap, trap_cause}); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    int mwc;
    do_reset();
    run_instr(ADDI, 1'b0, 15, 0, 30);
    checks++; if ({got_trap, got_cause, n_cyc[7:0]} !== {3'b110, 8'd16}) begin
      failures++; $display("FAIL fetch_timeout got=%b/%0d exp=110/16", {got_trap, got_cause}, n_cyc); end
    do_reset();
    run_instr(ADDI, 1'b0, 14, 0, 30);
    checks++; if ({got_trap, n_cyc[7:0]} !== {1'b0, 8'd18}) begin
      failures++; $display("FAIL fetch_limit_ready got=%b/%0d exp=0/18", got_trap, n_cyc); end
    run_instr(LW, 1'b0, 0, 15, 40);
    checks++; if ({got_trap, got_cause, n_cyc[7:0]} !== {3'b110, 8'd19}) begin
      failures++; $display("FAIL memread_timeout got=%b/%0d exp=110/19", {got_trap, got_cause}, n_cyc); end
    do_reset();
    run_instr(SW, 1'b0, 0, 14, 40);
    mwc = 0;
    for (int k = 0; k < n_cyc; k++) mwc += int'(s_mw[k]);
    checks++; if ({got_trap, n_cyc[7:0], mwc[7:0]} !== {1'b0, 8'd18, 8'd15}) begin
      failures++; $display("FAIL memwrite_limit_ready got=%b/%0d/%0d exp=0/18/15", got_trap, n_cyc, mwc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_instr(32'h0000007F, 1'b0, 0, 0, 10);
    do_reset();
    instr = SW; Zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    checks++; if ({trap, trap_cause} !== 3'b000) begin
      failures++; $display("FAIL rst_clears_trap got=%b exp=000", {trap, trap_cause}); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; mem_ready = 1'b0;
    @(negedge clk);
    checks++; if ({MemWrite, AdrSrc} !== 2'b11) begin
      failures++; $display("FAIL mid_sw_memwrite got=%b exp=11", {MemWrite, AdrSrc}); end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    checks++; if ({MemWrite, instr_retired, PCWrite, IRWrite, RegWrite} !== 5'b0) begin
      failures++; $display("FAIL mid_rst_strobes got=%b exp=00000", {MemWrite, instr_retired, PCWrite, IRWrite, RegWrite}); end
    @(posedge clk); #1; rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    checks++; if ({IRWrite, PCWrite, AdrSrc, MemWrite, trap} !== 5'b11000) begin
      failures++; $display("FAIL post_rst_fetch got=%b exp=11000", {IRWrite, PCWrite, AdrSrc, MemWrite, trap}); end
    @(posedge clk); #1;
  endtask

  // Model: latency and strobe counts follow from instruction class, Zero and wait lengths.
  task automatic test_random();
    logic [31:0] ins;
    logic [2:0]  f3, ealu;
    logic [2:0]  good_f3[4] = '{3'b000, 3'b010, 3'b110, 3'b111};
    logic [2:0]  alu_of[8]  = '{3'b000, 3'b000, 3'b101, 3'b000, 3'b000, 3'b000, 3'b011, 3'b010};
    logic [2:0]  bad_f3[4]  = '{3'b001, 3'b011, 3'b100, 3'b101};
    logic [6:0]  bad_op[4]  = '{7'b0110111, 7'b0010111, 7'b1100111, 7'b0000000};
    logic        z, b30, legal, chk_alu;
    int          fw, mw, kind, lat, erw, emw, epc, crw, cmw, cpc, cir;
    do_reset();
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 6); fw = $urandom_range(0, 3); mw = $urandom_range(0, 3);
      z = 1'($urandom); b30 = 1'($urandom);
      legal = 1; chk_alu = 0; ealu = 3'b000; erw = 0; emw = 0; epc = 1; lat = fw + 4;
      case (kind)
        0: begin ins = i_type(7'b0000011, 3'b010, b30); lat = fw + mw + 5; erw = 1; end
        1: begin ins = {7'($urandom), 5'($urandom), 5'($urandom), 3'b010, 5'($urandom), 7'b0100011};
                 lat = fw + mw + 4; emw = mw + 1; end
        2: begin f3 = good_f3[$urandom_range(0, 3)]; ins = r_type(b30, f3); erw = 1; chk_alu = 1;
                 ealu = (f3 == 3'b000 && b30) ? 3'b001 : alu_of[f3]; end
        3: begin f3 = good_f3[$urandom_range(0, 3)]; ins = i_type(7'b0010011, f3, b30); erw = 1;
                 chk_alu = 1; ealu = alu_of[f3]; end
        4: begin f3 = 3'($urandom_range(0, 1));
                 ins = {7'($urandom), 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b1100011};
                 lat = fw + 3; epc = (z != f3[0]) ? 2 : 1; end
        5: begin ins = {20'($urandom), 5'($urandom), 7'b1101111}; erw = 1; epc = 2; end
        default: begin
          legal = 0; lat = fw + 3;
          case ($urandom_range(0, 2))
            0: ins = r_type(b30, bad_f3[$urandom_range(0, 3)]);
            1: ins = i_type(7'b0010011, bad_f3[$urandom_range(0, 3)], b30);
            default: ins = i_type(bad_op[$urandom_range(0, 3)], 3'($urandom), b30);
          endcase
        end
      endcase
      run_instr(ins, z, fw, mw, 40);
      crw = 0; cmw = 0; cpc = 0; cir = 0;
      for (int k = 0; k < n_cyc && k < 64; k++) begin
        crw += int'(s_rw[k]); cmw += int'(s_mw[k]); cpc += int'(s_pcw[k]); cir += int'(s_irw[k]);
      end
      checks++; if (n_cyc !== lat) begin
        failures++; $display("FAIL rnd_latency[%0d] ins=%h got=%0d exp=%0d", it, ins, n_cyc, lat); end
      checks++; if ({got_trap, got_cause} !== (legal ? 3'b000 : 3'b101)) begin
        failures++; $display("FAIL rnd_trap[%0d] ins=%h got=%b exp=%b", it, ins, {got_trap, got_cause}, legal ? 3'b000 : 3'b101); end
      checks++; if ({crw, cmw, cpc, cir} !== {erw, emw, epc, 1}) begin
        failures++; $display("FAIL rnd_strobes[%0d] ins=%h got=rw%0d mw%0d pc%0d ir%0d exp=rw%0d mw%0d pc%0d ir1",
                             it, ins, crw, cmw, cpc, cir, erw, emw, epc); end
      if (chk_alu) begin
        checks++; if (s_alu[fw + 2] !== ealu) begin
          failures++; $display("FAIL rnd_alu[%0d] ins=%h got=%b exp=%b", it, ins, s_alu[fw + 2], ealu); end
      end
      if (!legal) do_reset();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; instr = 32'h0; Zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_addi();
    test_alu_decode();
    test_lw_wait();
    test_sw_wait();
    test_branch();
    test_jal();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore-style sequencing FSM for the multi-cycle RISC-V datapath. It decodes the instruction register, then steps the shared ALU, PC, instruction register, register file and unified memory through fetch/decode/execute/memory/writeback. It waits on a memory ready handshake and traps on illegal instructions or a memory timeout. It drives the datapath select and enable lines, including the existing 3-bit ALU control and 2-bit ImmSrc encodings consumed by the sign-extend unit.

Parameters:
DATA_WIDTH, 32, instruction width
CONTROL_WIDTH, 3, ALUControl width
MEM_TIMEOUT, 15, max cycles waiting for mem_ready before trap; 0 disables timeout
TIMEOUT_WIDTH, 4, width of wait counter; must hold MEM_TIMEOUT

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
instr  input  DATA_WIDTH  current instruction register contents
Zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current access this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address: 0=PC, 1=ALUOut
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction/OldPC register enable
ResultSrc  output  2  00=ALUOut, 01=read data, 10=ALUResult
ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1 register
ALUSrcB  output  2  00=rs2 register, 01=ImmExt, 10=constant 4
ALUControl  output  CONTROL_WIDTH  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  output  2  00=I, 01=S, 10=B, 11=J
RegWrite  output  1  register file write enable
instr_retired  output  1  one-cycle pulse in final cycle of each instruction
trap  output  1  sticky trap flag
trap_cause  output  2  00 none, 01 illegal instr, 10 memory timeout

Behaviour:
- State register and wait counter only. All outputs decode combinationally from the state, plus instr, Zero and mem_ready where stated. Unlisted outputs are 0; ALUControl defaults to 000.
- Supported ops: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, branch 1100011 (funct3 000 beq, 001 bne), jal 1101111.
- ALU decode for R and I types:
  - funct3 000: R with funct7[5]=1 gives sub; otherwise add (addi ignores funct7[5]).
  - funct3 010 gives slt, 110 gives or, 111 gives and.
  - Any other funct3 is illegal.
- ImmSrc decodes from op in every state: lw/I gives 00, sw gives 01, branch gives 10, jal gives 11.
- FETCH:
  - Drives AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite and PCWrite equal mem_ready.
  - mem_ready=1 goes to DECODE; otherwise the FSM stays in FETCH.
- DECODE:
  - Drives ALUSrcA=01, ALUSrcB=01, add (branch/jal target precompute).
  - Next state: lw/sw to MEMADR, R to EXECR, I to EXECI, branch to BRANCH, jal to JAL.
  - Unsupported op or funct3 goes to TRAP with cause 01.
- MEMADR: drives ALUSrcA=10, ALUSrcB=01, add. lw goes to MEMREAD; sw goes to MEMWRITE.
- MEMREAD: drives AdrSrc=1. mem_ready goes to MEMWB; otherwise it waits.
- MEMWB: drives ResultSrc=01, RegWrite=1, instr_retired=1, then goes to FETCH.
- MEMWRITE:
  - Drives AdrSrc=1 and holds MemWrite=1 every cycle until mem_ready.
  - On the mem_ready cycle: instr_retired=1 and the FSM goes to FETCH.
- EXECR: drives ALUSrcA=10, ALUSrcB=00, decoded ALUControl, then goes to ALUWB.
- EXECI: drives ALUSrcA=10, ALUSrcB=01, decoded ALUControl, then goes to ALUWB.
- ALUWB: drives ResultSrc=00, RegWrite=1, instr_retired=1, then goes to FETCH.
- JAL: drives ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then goes to ALUWB (rd=OldPC+4).
- BRANCH:
  - Drives ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = Zero XOR funct3[0].
  - instr_retired=1, then goes to FETCH.
- TRAP:
  - All enables and strobes are 0; trap=1 with cause held.
  - The FSM stays in TRAP until rst.
- Wait counter:
  - Clears on entry to FETCH, MEMREAD and MEMWRITE.
  - Increments each cycle those states see mem_ready=0.
  - If the counter reaches MEM_TIMEOUT with mem_ready=0, the next state is TRAP with cause 10 (when MEM_TIMEOUT≠0).
  - mem_ready=1 on the same cycle as the limit wins: the access completes and no trap occurs.
- Latency with mem_ready=1 throughout: R/I/jal take 4 cycles, lw 5, sw 4, branch 3.
- Reset:
  - On the clk edge with rst=1: state=FETCH, counter=0, trap=0, trap_cause=00.
  - While rst is high, PCWrite, IRWrite, MemWrite, RegWrite and instr_retired are forced 0.
  - Reset mid-instruction abandons the instruction with no further strobes.

Test Plan:
- addi x1,x0,5 (0x00500093), mem_ready=1 -> states FETCH,DECODE,EXECI,ALUWB; cycle 3 ALUSrcB=01 ALUControl=000; cycle 4 RegWrite=1 instr_retired=1.
- sub (0x40208033) -> EXECR ALUControl=001, ALUSrcB=00; and (0x0020F033) -> 010; slt funct3 010 -> 101.
- lw (0x0000A103) with mem_ready low 3 cycles in MEMREAD -> AdrSrc=1 held 4 cycles, then MEMWB ResultSrc=01 RegWrite=1; total 8 cycles.
- sw (0x0020A023), mem_ready low 2 cycles -> MemWrite=1 for exactly 3 cycles, ImmSrc=01, retire on third.
- beq Zero=1 -> PCWrite=1; bne (funct3 001) Zero=1 -> PCWrite=0; 3 cycles each.
- instr=0x0000007F -> TRAP, trap=1 cause=01, no enables for 10 cycles; mem_ready held 0 in FETCH for 15 cycles -> cause 10; rst high one cycle mid-MEMWRITE -> FETCH, MemWrite=0, trap cleared.
